// File: rtl/fifo_rd_fwft_stage.sv
// fifo_rd_fwft_stage: first-word-fall-through output stage with a 2-entry buffer for the async FIFO read side
module fifo_rd_fwft_stage #(
    parameter int DATA_SIZE = 8,
    parameter int WCNT_SIZE = 16
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic                 rd_empty,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic                 rd_ena,
    output logic [DATA_SIZE-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [1:0]           buf_level,
    output logic [WCNT_SIZE-1:0] word_cnt
);
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

    state_t               state, state_nxt;
    logic [DATA_SIZE-1:0] slot0, slot1, slot0_nxt, slot1_nxt;
    logic                 pop, fetch;

    // The state encoding is the occupancy, so it drives buf_level directly.
    assign buf_level  = state;
    assign dout_valid = (state != EMPTY);
    assign dout       = slot0;
    assign pop        = dout_valid & dout_ready;
    // Fetch looks only at registered state, so dout_ready never reaches rd_ena combinationally.
    assign fetch      = !rd_rst & !rd_empty & (state != TWO);
    assign rd_ena     = fetch;

    // State and slot registers; reset discards anything buffered.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            state <= EMPTY;
            slot0 <= '0;
            slot1 <= '0;
        end else begin
            state <= state_nxt;
            slot0 <= slot0_nxt;
            slot1 <= slot1_nxt;
        end
    end

    // Next occupancy and slot contents: fetched data lands at index (level - pop).
    always_comb begin
        state_nxt = state;
        slot0_nxt = slot0;
        slot1_nxt = slot1;
        case (state)
            EMPTY: begin
                if (fetch) begin
                    state_nxt = ONE;
                    slot0_nxt = mem_rdata;
                end
            end
            ONE: begin
                if (fetch && pop) begin
                    slot0_nxt = mem_rdata;
                end else if (fetch) begin
                    state_nxt = TWO;
                    slot1_nxt = mem_rdata;
                end else if (pop) begin
                    state_nxt = EMPTY;
                end
            end
            TWO: begin
                if (pop) begin
                    state_nxt = ONE;
                    slot0_nxt = slot1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Saturating count of words the consumer has taken.
    always_ff @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) word_cnt <= '0;
        else if (pop && word_cnt != {WCNT_SIZE{1'b1}}) word_cnt <= word_cnt + {{(WCNT_SIZE-1){1'b0}}, 1'b1};
    end
endmodule

// File: tb/tb_fifo_rd_fwft_stage.sv
// tb_fifo_rd_fwft_stage: queue-model check of the FWFT output stage with directed scenarios
module tb_fifo_rd_fwft_stage;
    logic        rd_clk = 1'b0;
    logic        rd_rst = 1'b1;
    logic        rd_empty;
    logic [7:0]  mem_rdata;
    logic        rd_ena, rd_ena_s;
    logic [7:0]  dout, dout_s;
    logic        dout_valid, dout_valid_s;
    logic        dout_ready = 1'b0;
    logic [1:0]  buf_level, buf_level_s;
    logic [15:0] word_cnt;
    logic [3:0]  word_cnt_s;

    logic [7:0]  src [64];
    int          rd_idx = 0;
    int          avail = 0;
    logic        force_empty = 1'b0;

    int          n_cmp = 0;
    int          n_err = 0;

    logic [7:0]  q [$];
    logic [7:0]  got [$];
    int          cnt = 0;
    int          cyc_n = 0;
    int          first_pop = -1;
    int          last_pop = -1;
    bit          mp, mf;

    fifo_rd_fwft_stage #(.DATA_SIZE(8), .WCNT_SIZE(16)) u_dut (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .mem_rdata(mem_rdata),
        .rd_ena(rd_ena), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .buf_level(buf_level), .word_cnt(word_cnt)
    );

    fifo_rd_fwft_stage #(.DATA_SIZE(8), .WCNT_SIZE(4)) u_sat (
        .rd_clk(rd_clk), .rd_rst(rd_rst), .rd_empty(rd_empty), .mem_rdata(mem_rdata),
        .rd_ena(rd_ena_s), .dout(dout_s), .dout_valid(dout_valid_s), .dout_ready(dout_ready),
        .buf_level(buf_level_s), .word_cnt(word_cnt_s)
    );

    always #5 rd_clk = ~rd_clk;

    assign rd_empty  = force_empty || (rd_idx >= avail);
    assign mem_rdata = src[rd_idx % 64];

    // Pointer-block stand-in: advances the read index on every popped word.
    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) rd_idx <= 0;
        else if (rd_ena) rd_idx <= rd_idx + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: a plain FIFO of at most two words plus a log of what the consumer took.
    always @(posedge rd_clk or posedge rd_rst) begin
        if (rd_rst) begin
            q.delete();
            got.delete();
            cnt = 0;
            cyc_n = 0;
            first_pop = -1;
            last_pop = -1;
        end else begin
            mp = (q.size() > 0) && dout_ready;
            mf = !rd_empty && (q.size() < 2);
            if (mp) begin
                got.push_back(q.pop_front());
                if (first_pop < 0) first_pop = cyc_n;
                last_pop = cyc_n;
                cnt++;
            end
            if (mf) q.push_back(mem_rdata);
            cyc_n++;
        end
    end

    // Every cycle out of reset, both instances must match the reference.
    always @(posedge rd_clk) begin
        #1;
        if (!rd_rst) begin
            chk("valid", {31'd0, dout_valid}, {31'd0, q.size() > 0});
            chk("level", {30'd0, buf_level}, q.size());
            chk("rd_ena", {31'd0, rd_ena}, {31'd0, !rd_empty && q.size() < 2});
            chk("word_cnt", {16'd0, word_cnt}, cnt);
            chk("word_cnt_sat", {28'd0, word_cnt_s}, (cnt > 15) ? 15 : cnt);
            chk("level_sat", {30'd0, buf_level_s}, q.size());
            chk("rd_ena_sat", {31'd0, rd_ena_s}, {31'd0, rd_ena});
            chk("valid_sat", {31'd0, dout_valid_s}, {31'd0, dout_valid});
            if (q.size() > 0) begin
                chk("dout", {24'd0, dout}, {24'd0, q[0]});
                chk("dout_sat", {24'd0, dout_s}, {24'd0, q[0]});
            end
        end
    end

    task automatic do_reset();
        @(negedge rd_clk);
        rd_rst = 1'b1;
        force_empty = 1'b0;
        avail = 0;
        dout_ready = 1'b0;
        #3;
        rd_rst = 1'b0;
    endtask

    initial begin
        // Reset with data available: rd_ena must stay low.
        src[0] = 8'h11;
        avail = 1;
        repeat (2) @(negedge rd_clk);
        chk("t1_rd_ena", {31'd0, rd_ena}, 32'd0);
        chk("t1_valid", {31'd0, dout_valid}, 32'd0);
        chk("t1_level", {30'd0, buf_level}, 32'd0);
        chk("t1_cnt", {16'd0, word_cnt}, 32'd0);

        // First word falls through one edge after rd_empty drops.
        do_reset();
        src[0] = 8'hA5;
        avail = 1;
        #1;
        chk("t2_rd_ena_hi", {31'd0, rd_ena}, 32'd1);
        @(negedge rd_clk);
        chk("t2_rd_ena_lo", {31'd0, rd_ena}, 32'd0);
        chk("t2_dout", {24'd0, dout}, 32'hA5);
        chk("t2_valid", {31'd0, dout_valid}, 32'd1);
        @(negedge rd_clk);
        chk("t2_hold", {24'd0, dout}, 32'hA5);

        // Backpressure fills both slots, then releases in order.
        do_reset();
        src[0] = 8'h01; src[1] = 8'h02; src[2] = 8'h03;
        avail = 3;
        repeat (2) @(negedge rd_clk);
        chk("t3_level", {30'd0, buf_level}, 32'd2);
        chk("t3_rd_ena", {31'd0, rd_ena}, 32'd0);
        chk("t3_dout", {24'd0, dout}, 32'h01);
        repeat (2) @(negedge rd_clk);
        chk("t3_hold", {24'd0, dout}, 32'h01);
        dout_ready = 1'b1;
        repeat (4) @(negedge rd_clk);
        chk("t3_n", got.size(), 32'd3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t3_order", {24'd0, got[i]}, i + 1);
        chk("t3_final", {30'd0, buf_level}, 32'd0);

        // Streaming sixteen words back to back.
        do_reset();
        for (int i = 0; i < 16; i++) src[i] = 8'h40 + 8'(i);
        dout_ready = 1'b1;
        avail = 16;
        repeat (20) @(negedge rd_clk);
        chk("t4_cnt", {16'd0, word_cnt}, 32'd16);
        chk("t4_n", got.size(), 32'd16);
        for (int i = 0; i < 16 && i < got.size(); i++) chk("t4_order", {24'd0, got[i]}, 32'h40 + i);
        chk("t4_span", last_pop - first_pop, 32'd15);

        // Drain with rd_empty raised while full.
        do_reset();
        src[0] = 8'h77; src[1] = 8'h88; src[2] = 8'h99; src[3] = 8'hAA;
        avail = 4;
        repeat (2) @(negedge rd_clk);
        chk("t5_level", {30'd0, buf_level}, 32'd2);
        force_empty = 1'b1;
        dout_ready = 1'b1;
        #1;
        chk("t5_rd_ena", {31'd0, rd_ena}, 32'd0);
        repeat (3) @(negedge rd_clk);
        chk("t5_n", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("t5_w0", {24'd0, got[0]}, 32'h77);
            chk("t5_w1", {24'd0, got[1]}, 32'h88);
        end
        chk("t5_level0", {30'd0, buf_level}, 32'd0);
        chk("t5_valid0", {31'd0, dout_valid}, 32'd0);

        // Asynchronous reset while full.
        do_reset();
        src[0] = 8'h5A; src[1] = 8'h5B;
        avail = 2;
        repeat (2) @(negedge rd_clk);
        chk("t6_level", {30'd0, buf_level}, 32'd2);
        #2;
        rd_rst = 1'b1;
        #1;
        chk("t6_valid", {31'd0, dout_valid}, 32'd0);
        chk("t6_level0", {30'd0, buf_level}, 32'd0);
        chk("t6_dout", {24'd0, dout}, 32'd0);
        chk("t6_rd_ena", {31'd0, rd_ena}, 32'd0);

        // Twenty pops saturate the narrow counter.
        do_reset();
        for (int i = 0; i < 20; i++) src[i] = 8'(i * 3);
        dout_ready = 1'b1;
        avail = 20;
        repeat (25) @(negedge rd_clk);
        chk("t7_sat", {28'd0, word_cnt_s}, 32'hF);
        chk("t7_cnt", {16'd0, word_cnt}, 32'd20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
